clock_set_ctrl: RTL and testbench

// - Button-driven setting controller for the DigitalClock core: sequences edits of time and alarm (HH:MM, BCD digits).
// - Drives the core's H_in1/H_in0/M_in1/M_in0, LD_time, LD_alarm, AL_ON and stop inputs; reads back the Alarm output and the current time.
// - Sits between the debounced front-panel buttons and DigitalClock. Only this block drives the core's load and config pins.

---
 rtl/clock_set_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Button-driven time/alarm setting controller for the DigitalClock core.
// Optional build macro AUTOREPEAT_EN adds auto-repeat on a held btn_inc.
module clock_set_ctrl #(
  parameter int LD_CYC      = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int STOP_CYC    = 10,
  parameter int REPEAT_DLY  = 50000,
  parameter int REPEAT_PER  = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_ok,
  input  logic       btn_alarm,
  input  logic       btn_stop,
  input  logic       alarm,
  input  logic [1:0] H_cur1,
  input  logic [3:0] H_cur0,
  input  logic [2:0] M_cur1,
  input  logic [3:0] M_cur0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [2:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       AL_ON,
  output logic       stop,
  output logic [1:0] edit_field,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_T_HR, S_T_MIN, S_T_LOAD, S_A_HR, S_A_MIN, S_A_LOAD
  } state_t;

  localparam int LD_W   = $clog2(LD_CYC + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int STOP_W = $clog2(STOP_CYC + 1);

  // Edit value packed as {H1, H0, M1, M0}.
  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [2:0] m1;
    logic [3:0] m0;
  } hhmm_t;

  state_t            r_state, w_state_nxt;
  hhmm_t             r_edit, w_edit_nxt, r_shadow;
  logic [4:0]        r_btn_prev;
  logic [4:0]        w_btn, w_evt;
  logic              w_mode, w_ok, w_inc, w_rep, w_any_evt, w_timeout;
  logic [LD_W-1:0]   r_ld_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [STOP_W-1:0] r_stop_cnt;
  logic              r_ld_time, r_ld_alarm, r_al_on, r_stop, r_busy;
  logic [1:0]        r_edit_field;

  function automatic hhmm_t inc_hour(input hhmm_t v);
    hhmm_t r = v;
    if (v.h1 == 2'd2 && v.h0 == 4'd3) begin
      r.h1 = 2'd0;
      r.h0 = 4'd0;
    end else if (v.h0 == 4'd9) begin
      r.h1 = v.h1 + 2'd1;
      r.h0 = 4'd0;
    end else begin
      r.h0 = v.h0 + 4'd1;
    end
    return r;
  endfunction

  // Minute wrap deliberately leaves the hour digits untouched.
  function automatic hhmm_t inc_min(input hhmm_t v);
    hhmm_t r = v;
    if (v.m1 == 3'd5 && v.m0 == 4'd9) begin
      r.m1 = 3'd0;
      r.m0 = 4'd0;
    end else if (v.m0 == 4'd9) begin
      r.m1 = v.m1 + 3'd1;
      r.m0 = 4'd0;
    end else begin
      r.m0 = v.m0 + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      S_T_HR, S_A_HR:     return 2'd1;
      S_T_MIN, S_A_MIN:   return 2'd2;
      S_T_LOAD, S_A_LOAD: return 2'd3;
      default:            return 2'd0;
    endcase
  endfunction

  assign w_btn     = {btn_stop, btn_alarm, btn_ok, btn_inc, btn_mode};
  assign w_evt     = w_btn & ~r_btn_prev;
  assign w_mode    = w_evt[0];
  assign w_ok      = w_evt[2] & ~w_mode;
  assign w_inc     = (w_evt[1] | w_rep) & ~w_mode & ~w_evt[2];
  assign w_any_evt = (|w_evt) | w_rep;
  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) && !w_any_evt;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs -- no latches.
    w_state_nxt = r_state;
    w_edit_nxt  = r_edit;
    case (r_state)
      S_IDLE: if (w_mode) begin
        w_state_nxt = S_T_HR;
        w_edit_nxt  = '{h1: H_cur1, h0: H_cur0, m1: M_cur1, m0: M_cur0};
      end
      S_T_HR, S_T_MIN: begin
        if (w_mode) begin
          w_state_nxt = S_A_HR;
          w_edit_nxt  = r_shadow;
        end else if (w_timeout)  w_state_nxt = S_IDLE;
        else if (w_ok)           w_state_nxt = (r_state == S_T_HR) ? S_T_MIN : S_T_LOAD;
        else if (w_inc)          w_edit_nxt  = (r_state == S_T_HR) ? inc_hour(r_edit) : inc_min(r_edit);
      end
      S_A_HR, S_A_MIN: begin
        if (w_mode || w_timeout) w_state_nxt = S_IDLE;
        else if (w_ok)           w_state_nxt = (r_state == S_A_HR) ? S_A_MIN : S_A_LOAD;
        else if (w_inc)          w_edit_nxt  = (r_state == S_A_HR) ? inc_hour(r_edit) : inc_min(r_edit);
      end
      S_T_LOAD, S_A_LOAD: if (r_ld_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_edit       <= '0;
      r_shadow     <= '0;
      r_btn_prev   <= '0;
      r_ld_cnt     <= '0;
      r_to_cnt     <= '0;
      r_stop_cnt   <= '0;
      r_ld_time    <= 1'b0;
      r_ld_alarm   <= 1'b0;
      r_al_on      <= 1'b0;
      r_stop       <= 1'b0;
      r_busy       <= 1'b0;
      r_edit_field <= 2'd0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      r_btn_prev   <= w_btn;
      r_state      <= w_state_nxt;
      r_edit       <= w_edit_nxt;
      r_edit_field <= field_of(w_state_nxt);
      r_busy       <= (w_state_nxt != S_IDLE);

      if (w_state_nxt == S_T_LOAD && r_state != S_T_LOAD) begin
        r_ld_time <= 1'b1;
        r_ld_cnt  <= LD_W'(LD_CYC - 1);
      end else if (w_state_nxt == S_A_LOAD && r_state != S_A_LOAD) begin
        r_ld_alarm <= 1'b1;
        r_ld_cnt   <= LD_W'(LD_CYC - 1);
      end else if (r_state == S_T_LOAD || r_state == S_A_LOAD) begin
        if (r_ld_cnt == '0) begin
          r_ld_time  <= 1'b0;
          r_ld_alarm <= 1'b0;
          if (r_state == S_A_LOAD) r_shadow <= r_edit;
        end else begin
          r_ld_cnt <= r_ld_cnt - LD_W'(1);
        end
      end

      if (w_any_evt || w_state_nxt != r_state)
        r_to_cnt <= '0;
      else if (r_state inside {S_T_HR, S_T_MIN, S_A_HR, S_A_MIN})
        r_to_cnt <= r_to_cnt + TO_W'(1);

      if (r_state == S_IDLE && w_evt[3]) r_al_on <= ~r_al_on;

      // A retrigger reloads the count, stretching the strobe.
      if (w_evt[4] && alarm) begin
        r_stop     <= 1'b1;
        r_stop_cnt <= STOP_W'(STOP_CYC - 1);
      end else if (r_stop) begin
        if (r_stop_cnt == '0) r_stop     <= 1'b0;
        else                  r_stop_cnt <= r_stop_cnt - STOP_W'(1);
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int RP_W = $clog2(REPEAT_DLY + 1);
  logic [RP_W-1:0] r_rep_cnt;
  logic            w_inc_held;

  // After the first repeat the count restarts at DLY-PER so later repeats come every PER.
  assign w_inc_held = btn_inc & r_btn_prev[1];
  assign w_rep      = w_inc_held && (r_rep_cnt == RP_W'(REPEAT_DLY - 1));

  always_ff @(posedge clk) begin
    if (!reset)                                        r_rep_cnt <= '0;
    else if (!w_inc_held || w_state_nxt != r_state)    r_rep_cnt <= '0;
    else if (w_rep)                                    r_rep_cnt <= RP_W'(REPEAT_DLY - REPEAT_PER);
    else                                               r_rep_cnt <= r_rep_cnt + RP_W'(1);
  end
`else
  assign w_rep = 1'b0;
`endif

  assign H_in1      = r_edit.h1;
  assign H_in0      = r_edit.h0;
  assign M_in1      = r_edit.m1;
  assign M_in0      = r_edit.m0;
  assign LD_time    = r_ld_time;
  assign LD_alarm   = r_ld_alarm;
  assign AL_ON      = r_al_on;
  assign stop       = r_stop;
  assign edit_field = r_edit_field;
  assign busy       = r_busy;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl (short timeout/repeat parameters).
module tb_clock_set_ctrl;

  localparam int LD_CYC      = 4;
  localparam int TIMEOUT_CYC = 200;
  localparam int STOP_CYC    = 10;
  localparam int REPEAT_DLY  = 50;
  localparam int REPEAT_PER  = 10;

  localparam int B_MODE = 0, B_INC = 1, B_OK = 2, B_ALARM = 3, B_STOP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  btn;
  logic        alarm;
  logic [1:0]  H_cur1;
  logic [3:0]  H_cur0;
  logic [2:0]  M_cur1;
  logic [3:0]  M_cur0;
  logic [1:0]  H_in1;
  logic [3:0]  H_in0;
  logic [2:0]  M_in1;
  logic [3:0]  M_in0;
  logic        LD_time, LD_alarm, AL_ON, stop, busy;
  logic [1:0]  edit_field;

  int n_tests = 0;
  int n_fail  = 0;

  // Strobe monitor: counts are monotonic; tests compare differences.
  int          n_ldt = 0, n_lda = 0, n_stop = 0;
  logic [12:0] cap = '0, prev_edit = '0;
  logic        both_seen = 1'b0, chg_seen = 1'b0;

  clock_set_ctrl #(
    .LD_CYC(LD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .STOP_CYC(STOP_CYC),
    .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn[B_MODE]), .btn_inc(btn[B_INC]), .btn_ok(btn[B_OK]),
    .btn_alarm(btn[B_ALARM]), .btn_stop(btn[B_STOP]),
    .alarm(alarm),
    .H_cur1(H_cur1), .H_cur0(H_cur0), .M_cur1(M_cur1), .M_cur0(M_cur0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .AL_ON(AL_ON), .stop(stop),
    .edit_field(edit_field), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (LD_time)  begin n_ldt++; cap = {H_in1, H_in0, M_in1, M_in0}; end
    if (LD_alarm) begin n_lda++; cap = {H_in1, H_in0, M_in1, M_in0}; end
    if (LD_time && LD_alarm) both_seen = 1'b1;
    if ((LD_time || LD_alarm) && {H_in1, H_in0, M_in1, M_in0} != prev_edit) chg_seen = 1'b1;
    prev_edit = {H_in1, H_in0, M_in1, M_in0};
    if (stop) n_stop++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int idx);
    btn[idx] = 1'b1;
    tick(2);
    btn[idx] = 1'b0;
    tick(2);
  endtask

  task automatic set_cur(input logic [1:0] h1, input logic [3:0] h0,
                         input logic [2:0] m1, input logic [3:0] m0);
    H_cur1 = h1; H_cur0 = h0; M_cur1 = m1; M_cur0 = m0;
  endtask

  task automatic test_reset;
    reset = 1'b0; btn = '0; alarm = 1'b0;
    set_cur(2'd0, 4'd0, 3'd0, 4'd0);
    tick(2);
    n_tests++;
    if ({H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, AL_ON, stop, edit_field} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=0",
               {H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, AL_ON, stop, edit_field});
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_time_load;
    int b_t, b_a;
    set_cur(2'd1, 4'd5, 3'd3, 4'd9);
    press(B_MODE);
    n_tests++;
    if ({busy, edit_field, H_in1, H_in0, M_in1, M_in0} !== {1'b1, 2'd1, 2'd1, 4'd5, 3'd3, 4'd9}) begin
      n_fail++;
      $display("FAIL tl_seed got=%h want=%h", {busy, edit_field, H_in1, H_in0, M_in1, M_in0},
               {1'b1, 2'd1, 2'd1, 4'd5, 3'd3, 4'd9});
    end
    press(B_OK);
    n_tests++;
    if (edit_field !== 2'd2) begin n_fail++; $display("FAIL tl_min_field got=%0d want=2", edit_field); end
    b_t = n_ldt; b_a = n_lda;
    press(B_OK);
    n_tests++;
    if (edit_field !== 2'd3) begin n_fail++; $display("FAIL tl_load_field got=%0d want=3", edit_field); end
    tick(10);
    n_tests++;
    if (n_ldt - b_t !== LD_CYC) begin n_fail++; $display("FAIL tl_ld_len got=%0d want=%0d", n_ldt - b_t, LD_CYC); end
    n_tests++;
    if (cap !== {2'd1, 4'd5, 3'd3, 4'd9}) begin n_fail++; $display("FAIL tl_ld_value got=%h want=%h", cap, {2'd1, 4'd5, 3'd3, 4'd9}); end
    n_tests++;
    if (n_lda - b_a !== 0) begin n_fail++; $display("FAIL tl_no_ld_alarm got=%0d want=0", n_lda - b_a); end
    n_tests++;
    if ({busy, edit_field} !== 3'b000) begin n_fail++; $display("FAIL tl_idle got=%b want=000", {busy, edit_field}); end
  endtask

  task automatic test_wrap;
    int b_t;
    set_cur(2'd2, 4'd2, 3'd5, 4'd8);
    press(B_MODE);
    press(B_INC);
    n_tests++;
    if ({H_in1, H_in0} !== {2'd2, 4'd3}) begin n_fail++; $display("FAIL wr_hour23 got=%h want=23", {H_in1, H_in0}); end
    press(B_INC);
    n_tests++;
    if ({H_in1, H_in0, M_in1, M_in0} !== {2'd0, 4'd0, 3'd5, 4'd8}) begin
      n_fail++; $display("FAIL wr_hour00 got=%h want=%h", {H_in1, H_in0, M_in1, M_in0}, {2'd0, 4'd0, 3'd5, 4'd8});
    end
    press(B_OK);
    press(B_INC);
    n_tests++;
    if ({M_in1, M_in0} !== {3'd5, 4'd9}) begin n_fail++; $display("FAIL wr_min59 got=%h want=59", {M_in1, M_in0}); end
    press(B_INC);
    n_tests++;
    if ({H_in1, H_in0, M_in1, M_in0} !== 13'd0) begin
      n_fail++; $display("FAIL wr_min00_nocarry got=%h want=0", {H_in1, H_in0, M_in1, M_in0});
    end
    b_t = n_ldt;
    press(B_OK);
    tick(10);
    n_tests++;
    if ((n_ldt - b_t !== LD_CYC) || (cap !== 13'd0)) begin
      n_fail++; $display("FAIL wr_load got_len=%0d got_val=%h want_len=%0d want_val=0", n_ldt - b_t, cap, LD_CYC);
    end
  endtask

  task automatic test_alarm_edit;
    int b_t, b_a;
    set_cur(2'd1, 4'd2, 3'd3, 4'd4);
    b_t = n_ldt; b_a = n_lda;
    press(B_MODE);
    press(B_MODE);
    n_tests++;
    if ({edit_field, H_in1, H_in0, M_in1, M_in0} !== {2'd1, 13'd0}) begin
      n_fail++; $display("FAIL al_seed_shadow got=%h want=%h", {edit_field, H_in1, H_in0, M_in1, M_in0}, {2'd1, 13'd0});
    end
    press(B_INC);
    press(B_OK);
    press(B_OK);
    tick(10);
    n_tests++;
    if ((n_lda - b_a !== LD_CYC) || (cap !== {2'd0, 4'd1, 3'd0, 4'd0})) begin
      n_fail++; $display("FAIL al_load got_len=%0d got_val=%h want_len=%0d want_val=%h",
                         n_lda - b_a, cap, LD_CYC, {2'd0, 4'd1, 3'd0, 4'd0});
    end
    n_tests++;
    if (n_ldt - b_t !== 0) begin n_fail++; $display("FAIL al_no_ld_time got=%0d want=0", n_ldt - b_t); end
    press(B_MODE);
    press(B_MODE);
    n_tests++;
    if ({H_in1, H_in0, M_in1, M_in0} !== {2'd0, 4'd1, 3'd0, 4'd0}) begin
      n_fail++; $display("FAIL al_reseed got=%h want=%h", {H_in1, H_in0, M_in1, M_in0}, {2'd0, 4'd1, 3'd0, 4'd0});
    end
    press(B_MODE);
    tick(2);
    n_tests++;
    if ((busy !== 1'b0) || (n_lda - b_a !== LD_CYC)) begin
      n_fail++; $display("FAIL al_abort got_busy=%b got_lda=%0d want_busy=0 want_lda=%0d", busy, n_lda - b_a, LD_CYC);
    end
  endtask

  task automatic test_stop_and_al_on;
    int b_s;
    alarm = 1'b1;
    b_s = n_stop;
    press(B_STOP);
    tick(15);
    n_tests++;
    if (n_stop - b_s !== STOP_CYC) begin n_fail++; $display("FAIL stop_len got=%0d want=%0d", n_stop - b_s, STOP_CYC); end
    alarm = 1'b0;
    b_s = n_stop;
    press(B_STOP);
    tick(15);
    n_tests++;
    if (n_stop - b_s !== 0) begin n_fail++; $display("FAIL stop_ignored got=%0d want=0", n_stop - b_s); end
    press(B_ALARM);
    n_tests++;
    if (AL_ON !== 1'b1) begin n_fail++; $display("FAIL al_on_set got=%b want=1", AL_ON); end
    press(B_ALARM);
    n_tests++;
    if (AL_ON !== 1'b0) begin n_fail++; $display("FAIL al_on_clear got=%b want=0", AL_ON); end
  endtask

  task automatic test_timeout;
    int b_t, b_a;
    b_t = n_ldt; b_a = n_lda;
    press(B_MODE);
    tick(TIMEOUT_CYC - 20);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL to_still_busy got=%b want=1", busy); end
    tick(40);
    n_tests++;
    if ({busy, edit_field} !== 3'b000) begin n_fail++; $display("FAIL to_idle got=%b want=000", {busy, edit_field}); end
    n_tests++;
    if ((n_ldt - b_t) + (n_lda - b_a) !== 0) begin
      n_fail++; $display("FAIL to_no_load got=%0d want=0", (n_ldt - b_t) + (n_lda - b_a));
    end
  endtask

  task automatic test_priority;
    press(B_MODE);
    btn = 5'b00101;  // mode + ok together
    tick(2);
    btn = '0;
    tick(2);
    n_tests++;
    if ({edit_field, H_in1, H_in0, M_in1, M_in0} !== {2'd1, 2'd0, 4'd1, 3'd0, 4'd0}) begin
      n_fail++; $display("FAIL pri_mode_wins got=%h want=%h", {edit_field, H_in1, H_in0, M_in1, M_in0},
                         {2'd1, 2'd0, 4'd1, 3'd0, 4'd0});
    end
    btn = 5'b00110;  // ok + inc together
    tick(2);
    btn = '0;
    tick(2);
    n_tests++;
    if ({edit_field, H_in1, H_in0} !== {2'd2, 2'd0, 4'd1}) begin
      n_fail++; $display("FAIL pri_ok_over_inc got=%h want=%h", {edit_field, H_in1, H_in0}, {2'd2, 2'd0, 4'd1});
    end
    press(B_MODE);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL pri_abort got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid_load;
    int budget;
    set_cur(2'd0, 4'd7, 3'd1, 4'd5);
    press(B_MODE);
    press(B_OK);
    btn[B_OK] = 1'b1;
    budget = 0;
    while (LD_time !== 1'b1 && budget < 10) begin
      tick(1);
      budget++;
    end
    btn[B_OK] = 1'b0;
    n_tests++;
    if (LD_time !== 1'b1) begin
      n_fail++; $display("FAIL rml_wait_load got=%b want=1", LD_time);
    end
    reset = 1'b0;
    tick(1);
    n_tests++;
    if ({LD_time, busy, H_in1, H_in0, M_in1, M_in0} !== 15'd0) begin
      n_fail++; $display("FAIL rml_drop got=%h want=0", {LD_time, busy, H_in1, H_in0, M_in1, M_in0});
    end
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_autorepeat;
    logic [6:0] exp_min;
`ifdef AUTOREPEAT_EN
    exp_min = {3'd0, 4'd4};
`else
    exp_min = {3'd0, 4'd1};
`endif
    set_cur(2'd1, 4'd0, 3'd0, 4'd0);
    press(B_MODE);
    press(B_OK);
    btn[B_INC] = 1'b1;
    tick(REPEAT_DLY + 2 * REPEAT_PER + 2);
    btn[B_INC] = 1'b0;
    tick(2);
    n_tests++;
    if ({H_in1, H_in0, M_in1, M_in0} !== {2'd1, 4'd0, exp_min}) begin
      n_fail++; $display("FAIL rep_minutes got=%h want=%h", {H_in1, H_in0, M_in1, M_in0}, {2'd1, 4'd0, exp_min});
    end
    press(B_MODE);
    press(B_MODE);
  endtask

  task automatic test_strobe_invariants;
    n_tests++;
    if (both_seen !== 1'b0) begin n_fail++; $display("FAIL inv_both_strobes got=%b want=0", both_seen); end
    n_tests++;
    if (chg_seen !== 1'b0) begin n_fail++; $display("FAIL inv_edit_during_strobe got=%b want=0", chg_seen); end
  endtask

  initial begin
    test_reset();
    test_time_load();
    test_wrap();
    test_alarm_edit();
    test_stop_and_al_on();
    test_timeout();
    test_priority();
    test_reset_mid_load();
    test_autorepeat();
    test_strobe_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
